// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared definitions for the OV7670 capture controller.
//   - default frame geometry (VGA 640 x 480)
//   - capture FSM state encoding
package ov7670_pkg;

    localparam int unsigned H_PIX_DEF   = 640;
    localparam int unsigned V_LINES_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_ARMED   = 2'd2,
        ST_CAPTURE = 2'd3
    } cap_state_t;

endpackage

// File: rtl/ov7670_edge_det.sv
// ov7670_edge_det: rise/fall detector against a registered copy of the input.
// An input transition shows up on rise/fall in the cycle after it happens.
// Ports:
//   clk   in   clock (rising edge)
//   rst_n in   synchronous active-low reset (clears the stored copy)
//   din   in   signal to watch
//   rise  out  din is 1 and was 0 at the previous edge
//   fall  out  din is 0 and was 1 at the previous edge
module ov7670_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// ov7670_capture_ctrl: frame-level control for OV7670 capture.
// Waits for a complete vertical blanking interval before opening the capture
// gate, checks line/frame geometry and counts completed frames.
// Ports:
//   pclk       in   camera pixel clock
//   rst_n      in   synchronous active-low reset
//   start      in   one-cycle capture request (ignored while busy)
//   cont       in   continuous (1) / single-shot (0), latched with start
//   stop       in   one-cycle request to end capture after the current frame
//   vsync      in   camera vsync, high during vertical blanking
//   href       in   camera href, high during an active line
//   pix_we     in   pixel-written strobe from the capture datapath
//   cap_en     out  registered gate, high exactly while in CAPTURE
//   busy       out  high in every state except IDLE
//   frame_done out  one-cycle pulse when a captured frame ends
//   frame_err  out  sticky geometry error, cleared by an accepted start
//   frame_cnt  out  completed-frame counter, wraps
module ov7670_capture_ctrl
    import ov7670_pkg::*;
#(
    parameter int unsigned H_PIX   = H_PIX_DEF,
    parameter int unsigned V_LINES = V_LINES_DEF,
    parameter int unsigned FCNT_W  = 8
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              stop,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_we,
    output logic              cap_en,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned PIX_W  = $clog2(H_PIX + 2);
    localparam int unsigned LINE_W = $clog2(V_LINES + 2);

    localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(H_PIX);
    localparam logic [PIX_W-1:0]  PIX_SAT   = PIX_W'(H_PIX + 1);
    localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_LINES);
    localparam logic [LINE_W-1:0] LINE_SAT  = LINE_W'(V_LINES + 1);

    cap_state_t        state, state_d;
    logic              v_rise, v_fall, h_rise, h_fall;
    logic              cont_q, stop_q;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              start_acc, in_cap, stop_any;

    ov7670_edge_det u_vsync_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .din   (vsync),
        .rise  (v_rise),
        .fall  (v_fall)
    );

    ov7670_edge_det u_href_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .din   (href),
        .rise  (h_rise),
        .fall  (h_fall)
    );

    assign start_acc = (state == ST_IDLE) && start;
    assign in_cap    = (state == ST_CAPTURE);
    assign stop_any  = stop | stop_q;
    assign busy      = (state != ST_IDLE);

    // SYNC waits for a vsync rise so that ARMED always sees the whole
    // blanking interval; a frame already in progress is never opened.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    if (start) state_d = ST_SYNC;
            ST_SYNC:    if (stop_any) state_d = ST_IDLE;
                        else if (v_rise) state_d = ST_ARMED;
            ST_ARMED:   if (stop_any) state_d = ST_IDLE;
                        else if (v_fall) state_d = ST_CAPTURE;
            ST_CAPTURE: if (v_rise) state_d = (cont_q && !stop_any) ? ST_ARMED : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cap_en     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            cont_q     <= 1'b0;
            stop_q     <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
        end else begin
            state      <= state_d;
            cap_en     <= (state_d == ST_CAPTURE);
            frame_done <= in_cap && v_rise;

            if (start_acc) begin
                cont_q <= cont;
                stop_q <= 1'b0;
            end else if (state_d == ST_IDLE) begin
                stop_q <= 1'b0;
            end else if (stop) begin
                stop_q <= 1'b1;
            end

            if (start_acc) begin
                frame_err <= 1'b0;
            end else if (in_cap && h_fall && (pix_cnt != PIX_FULL)) begin
                frame_err <= 1'b1;
            end else if (in_cap && v_rise && (line_cnt != LINE_FULL)) begin
                frame_err <= 1'b1;
            end

            if (in_cap && v_rise) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end

            // A pixel strobe coinciding with the line-start clear still counts.
            if (h_rise) begin
                pix_cnt <= (in_cap && pix_we) ? PIX_W'(1) : '0;
            end else if (in_cap && pix_we && (pix_cnt != PIX_SAT)) begin
                pix_cnt <= pix_cnt + PIX_W'(1);
            end

            if (!in_cap && (state_d == ST_CAPTURE)) begin
                line_cnt <= '0;
            end else if (in_cap && h_fall && (line_cnt != LINE_SAT)) begin
                line_cnt <= line_cnt + LINE_W'(1);
            end
        end
    end

endmodule
